// File: rtl/dig_ct_pkg.sv
// Shared types and constants for the DigCt code tracker.
package dig_ct_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_S1,
      ST_S2
   } seq_state_t;

   localparam logic [2:0] CODE_IDLE = 3'b111;
   localparam logic [2:0] SEQ_A     = 3'b011;
   localparam logic [2:0] SEQ_B     = 3'b101;
   localparam logic [2:0] SEQ_C     = 3'b110;

   localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/dig_ct_debounce.sv
// Debouncer: a code is accepted once it has been sampled HOLD_MIN enabled cycles in a row.
module dig_ct_debounce
   import dig_ct_pkg::*;
#(
   parameter int unsigned HOLD_MIN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] code,
   output logic [2:0] stable_code,
   output logic       change
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD_MIN);

   logic [2:0]       cand;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_nxt;
   logic             differs;
   logic             reached;

   // change is the next-edge event strobe; the top registers everything it drives.
   always_comb begin
      differs = (code != cand);
      run_nxt = run;
      if (differs)
         run_nxt = RUN_W'(1);
      else if (run < RUN_MAX)
         run_nxt = run + RUN_W'(1);
      reached = (run_nxt == RUN_MAX) && (differs || (run != RUN_MAX));
      change  = en && reached && (code != stable_code);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand        <= CODE_IDLE;
         run         <= RUN_MAX;
         stable_code <= CODE_IDLE;
      end else if (en) begin
         cand <= code;
         run  <= run_nxt;
         if (change)
            stable_code <= code;
      end
   end

endmodule

// File: rtl/dig_ct_code_tracker.sv
// Tracks the debounced DigCt code: valid pulse, saturating change count and sequence detector.
module dig_ct_code_tracker
   import dig_ct_pkg::*;
#(
   parameter int unsigned HOLD_MIN = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CLR,
   input  logic [2:0]       CODE,
   output logic [2:0]       STABLE_CODE,
   output logic             CODE_VLD,
   output logic [CNT_W-1:0] CHG_CNT,
   output logic             SEQ_HIT
);

   seq_state_t state_q;
   seq_state_t state_d;
   logic       change;
   logic       hit_d;

   dig_ct_debounce #(
      .HOLD_MIN (HOLD_MIN)
   ) u_debounce (
      .clk         (CLK),
      .rst         (RST),
      .en          (EN),
      .code        (CODE),
      .stable_code (STABLE_CODE),
      .change      (change)
   );

   // On an event the accepted code equals CODE, so the FSM decodes CODE directly.
   always_comb begin
      state_d = state_q;
      hit_d   = 1'b0;
      if (change) begin
         unique case (state_q)
            ST_IDLE: state_d = (CODE == SEQ_A) ? ST_S1 : ST_IDLE;
            ST_S1: begin
               if (CODE == SEQ_B)      state_d = ST_S2;
               else if (CODE == SEQ_A) state_d = ST_S1;
               else                    state_d = ST_IDLE;
            end
            ST_S2: begin
               if (CODE == SEQ_C) begin
                  state_d = ST_IDLE;
                  hit_d   = 1'b1;
               end else if (CODE == SEQ_A) begin
                  state_d = ST_S1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         CODE_VLD <= 1'b0;
         SEQ_HIT  <= 1'b0;
         CHG_CNT  <= '0;
      end else begin
         state_q  <= state_d;
         CODE_VLD <= change;
         SEQ_HIT  <= hit_d;
         if (CLR)
            CHG_CNT <= '0;
         else if (change && (CHG_CNT != '1))
            CHG_CNT <= CHG_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dig_ct_code_tracker.sv
// Directed plus randomized bench for dig_ct_code_tracker against a history-based reference model.
module tb_dig_ct_code_tracker;

   localparam int unsigned HM = 3;
   localparam int unsigned CW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN  = 1'b0;
   logic          CLR = 1'b0;
   logic [2:0]    CODE = 3'b111;
   logic [2:0]    STABLE_CODE;
   logic          CODE_VLD;
   logic [CW-1:0] CHG_CNT;
   logic          SEQ_HIT;

   int checks = 0;
   int errors = 0;

   // Reference model state: recent enabled samples and list of accepted codes.
   logic [2:0] hist[$];
   logic [2:0] acc_q[$];
   logic [2:0] m_stable;
   int         m_cnt;
   logic       m_vld;
   logic       m_hit;

   dig_ct_code_tracker #(
      .HOLD_MIN (HM),
      .CNT_W    (CW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .EN          (EN),
      .CLR         (CLR),
      .CODE        (CODE),
      .STABLE_CODE (STABLE_CODE),
      .CODE_VLD    (CODE_VLD),
      .CHG_CNT     (CHG_CNT),
      .SEQ_HIT     (SEQ_HIT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".stable"}, 32'(STABLE_CODE), 32'(m_stable));
      check({tag, ".vld"},    32'(CODE_VLD),    32'(m_vld));
      check({tag, ".cnt"},    32'(CHG_CNT),     32'(m_cnt));
      check({tag, ".hit"},    32'(SEQ_HIT),     32'(m_hit));
   endtask

   task automatic model_reset();
      hist.delete();
      acc_q.delete();
      for (int i = 0; i <= int'(HM); i++) hist.push_back(3'b111);
      m_stable = 3'b111;
      m_cnt    = 0;
      m_vld    = 1'b0;
      m_hit    = 1'b0;
   endtask

   // Accepted when the newest HM samples agree and the sample before them did not.
   task automatic model_step(input logic en, input logic clr, input logic [2:0] code);
      logic all_eq;
      int   n;
      m_vld = 1'b0;
      m_hit = 1'b0;
      if (en) begin
         hist.push_back(code);
         while (hist.size() > int'(HM) + 1) void'(hist.pop_front());
         all_eq = 1'b1;
         for (int i = 1; i <= int'(HM); i++)
            if (hist[i] != code) all_eq = 1'b0;
         if (all_eq && hist[0] != code && code != m_stable) begin
            m_stable = code;
            m_vld    = 1'b1;
            acc_q.push_back(code);
            n = acc_q.size();
            if (n >= 3 && acc_q[n-3] == 3'b011 && acc_q[n-2] == 3'b101 && acc_q[n-1] == 3'b110)
               m_hit = 1'b1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
         end
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic step(input string tag, input logic en, input logic clr, input logic [2:0] code);
      @(negedge CLK);
      EN   = en;
      CLR  = clr;
      CODE = code;
      model_step(en, clr, code);
      @(posedge CLK);
      #1;
      check_all(tag);
   endtask

   task automatic hold(input string tag, input logic [2:0] code, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, code);
   endtask

   task automatic async_reset(input string tag);
      @(negedge CLK);
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      logic [2:0] rc;
      int         rn;
      model_reset();
      #12;
      check_all("por");
      @(negedge CLK);
      RST = 1'b0;

      // 1: reset mid-debounce, then idle code produces nothing
      hold("s1_pre", 3'b010, 2);
      async_reset("s1_rst");
      hold("s1_idle", 3'b111, 4);

      // 2: accept 010, then glitch-and-return ignored
      hold("s2_acc", 3'b010, 3);
      check("s2_stable_abs", 32'(STABLE_CODE), 32'h2);
      check("s2_cnt_abs", 32'(CHG_CNT), 32'h1);
      hold("s2_hold", 3'b010, 2);
      hold("s2_glitch", 3'b000, 1);
      hold("s2_back", 3'b010, 4);

      // 3: sequences
      hold("s3_a", 3'b011, 3);
      hold("s3_b", 3'b101, 3);
      hold("s3_c", 3'b110, 2);
      step("s3_c_last", 1'b1, 1'b0, 3'b110);
      check("s3_hit_abs", 32'(SEQ_HIT), 32'h1);
      hold("s3r_a", 3'b011, 3);
      hold("s3r_x", 3'b001, 1);
      hold("s3r_a2", 3'b011, 3);
      hold("s3r_b", 3'b101, 3);
      hold("s3r_c", 3'b110, 3);
      hold("s3n_a", 3'b011, 3);
      hold("s3n_b", 3'b100, 3);
      hold("s3n_c", 3'b110, 3);

      // 4: enable gating does not break stability
      hold("s4_pre", 3'b001, 2);
      for (int i = 0; i < 5; i++) step("s4_off", 1'b0, 1'b0, 3'($urandom_range(0, 7)));
      step("s4_on", 1'b1, 1'b0, 3'b001);
      check("s4_vld_abs", 32'(CODE_VLD), 32'h1);

      // 5: saturation and clear priority
      async_reset("s5_rst");
      for (int i = 0; i < 256; i++) hold("s5_sat", (i % 2 == 0) ? 3'b000 : 3'b001, 3);
      check("s5_sat_abs", 32'(CHG_CNT), 32'hFF);
      hold("s5_clr_pre", 3'b100, 2);
      step("s5_clr", 1'b1, 1'b1, 3'b100);
      check("s5_clr_cnt_abs", 32'(CHG_CNT), 32'h0);
      check("s5_clr_vld_abs", 32'(CODE_VLD), 32'h1);

      // 6: reset mid-sequence kills the pending hit
      hold("s6_a", 3'b011, 3);
      hold("s6_b", 3'b101, 3);
      async_reset("s6_rst");
      hold("s6_c", 3'b110, 4);
      check("s6_nohit_abs", 32'(SEQ_HIT), 32'h0);

      // random segments
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 1) == 0)
            rc = ($urandom_range(0, 2) == 0) ? 3'b011 : (($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110);
         else
            rc = 3'($urandom_range(0, 7));
         rn = $urandom_range(1, 5);
         for (int k = 0; k < rn; k++)
            step("rnd", ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), rc);
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dig_ct_code_tracker.md
# dig_ct_code_tracker

Downstream consumer of the registered 3-bit code produced by the DigCt logic stage, `{OUT3,OUT2,OUT1}`. It debounces the code, so a value is accepted only after it has held stable for `HOLD_MIN` enabled cycles. It publishes the accepted code with a one-cycle valid pulse and counts accepted changes in a saturating counter. A small FSM flags the accepted-code sequence 3'b011 → 3'b101 → 3'b110.

## Interface
Parameters:
- `HOLD_MIN`, default 3: enabled cycles a code must be stable before acceptance. Legal range 1..15.
- `CNT_W`, default 8: width of `CHG_CNT`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `EN` in 1: sample enable. When low, all state is frozen.
- `CLR` in 1: synchronous clear of `CHG_CNT`, independent of `EN`.
- `CODE` in 3: `{OUT3,OUT2,OUT1}` from the upstream stage.
- `STABLE_CODE` out 3: last accepted code.
- `CODE_VLD` out 1: one-cycle pulse when `STABLE_CODE` takes a new value.
- `CHG_CNT` out `CNT_W`: number of accepted changes, saturating at all-ones.
- `SEQ_HIT` out 1: one-cycle pulse when the sequence completes.

## Operation
Reset values:
- `STABLE_CODE` = 3'b111 (upstream idle value with all inputs low).
- `CODE_VLD`, `SEQ_HIT` = 0.
- `CHG_CNT` = 0.
- Internal candidate = 3'b111, run counter = `HOLD_MIN` (already stable), FSM = IDLE.

Debounce (evaluated only on edges where `EN`=1):
- If `CODE` ≠ candidate: candidate ← `CODE`, run ← 1.
- Else if run < `HOLD_MIN`: run ← run+1.
- Else: run holds at `HOLD_MIN`.
- Acceptance occurs on the edge where run becomes `HOLD_MIN`. For `HOLD_MIN`=1, this is the edge on which a new candidate is loaded.
- An accepted candidate equal to `STABLE_CODE` produces no event (glitch-and-return is ignored).
- Otherwise `STABLE_CODE` ← candidate, `CODE_VLD` ← 1 for exactly one cycle, and `CHG_CNT` ← `CHG_CNT`+1 unless already all-ones.

Clear and enable:
- `CLR`=1 forces `CHG_CNT` ← 0 and has priority over a same-edge increment. `CODE_VLD` still pulses.
- `EN`=0: candidate, run, `STABLE_CODE` and FSM hold; `CODE_VLD` and `SEQ_HIT` drive 0. An `EN`=0 cycle does not break stability.

Sequence FSM (advances only on acceptance events):
- IDLE: 011 → S1; anything else → IDLE.
- S1: 101 → S2; 011 → S1; else → IDLE.
- S2: 110 → IDLE with `SEQ_HIT`=1; 011 → S1; else → IDLE.
- Encoding lives in the package.

`RST` asserted at any time, including mid-debounce or mid-sequence, returns every register to its reset value immediately.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Acceptance latency: a code first sampled at enabled edge k is accepted at enabled edge k+`HOLD_MIN`−1. `STABLE_CODE`, `CODE_VLD`, `CHG_CNT` and `SEQ_HIT` update on that same edge.
- `SEQ_HIT` is coincident with the `CODE_VLD` pulse that carries 3'b110.
- Back-to-back `CODE_VLD` pulses are possible only when `HOLD_MIN`=1.
- Reset release: the first sampling edge is the first rising edge with `RST` low.

## Structure
- Package `dig_ct_pkg` holds:
  - FSM state typedef (IDLE, S1, S2).
  - Code constants `CODE_IDLE`=3'b111, `SEQ_A`=3'b011, `SEQ_B`=3'b101, `SEQ_C`=3'b110.
  - Run-counter width constant (4).
- One sub-module is natural: `dig_ct_debounce`, which contains candidate, run counter, `STABLE_CODE` and the acceptance strobe. The FSM and counter sit in the top level.

## Test plan
All scenarios use `HOLD_MIN`=3 and `CNT_W`=8.
1. Reset check: assert `RST` mid-run → `STABLE_CODE`=111, `CHG_CNT`=0, pulses 0, asynchronously. After release, `CODE`=111 held produces no `CODE_VLD`.
2. Debounce accept: `CODE`=010 for 3 enabled cycles → `CODE_VLD` is a single pulse on the 3rd edge, `STABLE_CODE`=010, `CHG_CNT`=1. Then `CODE`=010 held for 2 cycles, 000 for 1 cycle, back to 010 → no event.
3. Sequence hit: 011, 101, 110, each held 3 cycles → three `CODE_VLD` pulses, `SEQ_HIT`=1 with the third only. Also 011, 011-restart, 101, 110 → hit. 011, 100, 110 → no hit.
4. Enable gating: `CODE`=001 sampled 2 cycles, `EN`=0 for 5 cycles, `EN`=1 for 1 cycle → acceptance on that edge. Outputs frozen and pulses low while `EN`=0.
5. Counter edges: 256 alternating accepted changes → `CHG_CNT` saturates at 255. `CLR` coincident with an acceptance → `CHG_CNT`=0 and `CODE_VLD`=1.
6. Reset mid-sequence: after 011 and 101 are accepted, pulse `RST`, then apply 110 → no `SEQ_HIT`.
